// File: rtl/dp_mem_responder.sv
// Memory-side responder. It arbitrates instruction fetch against data access,
// drives a single word-wide RAM port, and returns one-cycle ihit/dhit pulses
// with registered load data. It also handles halt/flush and RAM timeouts.
module dp_mem_responder #(
    parameter int unsigned TIMEOUT = 255,
    parameter bit          D_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    input  logic        halt,
    output logic        flushed,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        ram_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic               is_d_q,     is_d_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ihit_q,     ihit_d;
    logic               dhit_q,     dhit_d;
    logic               ramren_q,   ramren_d;
    logic               ramwen_q,   ramwen_d;
    logic [31:0]        ramaddr_q,  ramaddr_d;
    logic [31:0]        ramstore_q, ramstore_d;
    logic [31:0]        imemload_q, imemload_d;
    logic [31:0]        dmemload_q, dmemload_d;
    logic               flushed_q,  flushed_d;
    logic               ram_err_q,  ram_err_d;

    logic               d_req;
    logic               pick_d;

    assign d_req  = dmemREN | dmemWEN;
    // Data wins a tie when D_FIRST is set; otherwise only when no fetch is pending.
    assign pick_d = d_req & (D_FIRST | ~imemREN);

    // State and datapath registers; reset drops any in-flight access at once.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q    <= IDLE;
            is_d_q     <= 1'b0;
            cnt_q      <= '0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            imemload_q <= '0;
            dmemload_q <= '0;
            flushed_q  <= 1'b0;
            ram_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_d_q     <= is_d_d;
            cnt_q      <= cnt_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            imemload_q <= imemload_d;
            dmemload_q <= dmemload_d;
            flushed_q  <= flushed_d;
            ram_err_q  <= ram_err_d;
        end
    end

    // Next-state and next-output logic; hit pulses default low so they last one cycle.
    always_comb begin
        state_d    = state_q;
        is_d_d     = is_d_q;
        cnt_d      = cnt_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        ramren_d   = ramren_q;
        ramwen_d   = ramwen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        imemload_d = imemload_q;
        dmemload_d = dmemload_q;
        flushed_d  = flushed_q;
        ram_err_d  = ram_err_q;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d   = HALTED;
                    flushed_d = 1'b1;
                end else if (d_req || imemREN) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    is_d_d  = pick_d;
                    if (pick_d) begin
                        ramwen_d   = dmemWEN;
                        ramren_d   = ~dmemWEN;
                        ramaddr_d  = dmemaddr;
                        ramstore_d = dmemstore;
                    end else begin
                        ramren_d  = 1'b1;
                        ramwen_d  = 1'b0;
                        ramaddr_d = imemaddr;
                    end
                end
            end

            ACCESS: begin
                if (ram_ready) begin
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    if (!is_d_q) begin
                        imemload_d = ramload;
                    end else if (ramren_q) begin
                        dmemload_d = ramload;
                    end
                    ihit_d  = ~is_d_q;
                    dhit_d  = is_d_q;
                    state_d = RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    ramren_d  = 1'b0;
                    ramwen_d  = 1'b0;
                    ram_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            HALTED: begin
                flushed_d = 1'b1;
                ramren_d  = 1'b0;
                ramwen_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = imemload_q;
    assign dmemload = dmemload_q;
    assign flushed  = flushed_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign ram_err  = ram_err_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: a latency-programmable RAM, a datapath-style
// requester, and a transaction-level model of expected hits, loads and errors.
module tb_dp_mem_responder;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        halt;
    logic        flushed;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        ram_err;

    dp_mem_responder #(.TIMEOUT(TO), .D_FIRST(1'b1)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .halt      (halt),
        .flushed   (flushed),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready),
        .ram_err   (ram_err)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    // RAM contents seen by the environment, and the model's own copy.
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ram_lat = 1;
    int          rcnt    = 0;

    logic [31:0] exp_iload = '0;
    logic [31:0] exp_dload = '0;
    bit          exp_err   = 1'b0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // RAM: completes a strobed access ram_lat cycles after the strobe rises.
    initial begin
        ram_ready = 1'b0;
        ramload   = '0;
        forever begin
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                rcnt++;
                if (rcnt == ram_lat) begin
                    ram_ready = 1'b1;
                    if (ramREN) ramload = ram_rd(ramaddr);
                    if (ramWEN) ram_mem[ramaddr] = ramstore;
                end else begin
                    ram_ready = 1'b0;
                    ramload   = $urandom;
                end
            end else begin
                rcnt      = 0;
                ram_ready = 1'b0;
            end
        end
    end

    // One datapath transaction; lat > TO means the RAM never answers in time.
    task automatic xact(input bit is_d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
        int strobes = 0;
        int hit_at  = 0;
        bit bad_addr = 0, bad_kind = 0, overlap = 0, got_i = 0, got_d = 0;
        bit to = (lat > TO);
        int budget = to ? TO + 1 : lat + 3;
        @(negedge CLK);
        ram_lat = lat;
        if (is_d) begin
            dmemaddr = addr; dmemstore = wdata; dmemWEN = wr; dmemREN = !wr;
        end else begin
            imemaddr = addr; imemREN = 1'b1;
        end
        for (int k = 1; k <= budget && hit_at == 0; k++) begin
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                strobes++;
                if (ramaddr !== addr) bad_addr = 1;
                if (is_d && wr && (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== wdata)) bad_kind = 1;
                if (!(is_d && wr) && (ramREN !== 1'b1 || ramWEN !== 1'b0)) bad_kind = 1;
            end
            if (ihit && dhit) overlap = 1;
            if (ihit || dhit) begin
                hit_at = k; got_i = ihit; got_d = dhit;
            end
        end
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;

        vectors++;
        if (bad_addr || bad_kind || overlap) begin
            errors++;
            $display("FAIL xact_port addr=%h: bad_addr=%0d bad_strobe=%0d overlap=%0d, required all 0",
                     addr, bad_addr, bad_kind, overlap);
        end
        if (!to) begin
            if (is_d && !wr) exp_dload = ref_rd(addr);
            if (!is_d)       exp_iload = ref_rd(addr);
            if (is_d && wr)  ref_mem[addr] = wdata;
            vectors++;
            if (hit_at !== lat + 1 || got_i !== !is_d || got_d !== is_d) begin
                errors++;
                $display("FAIL xact_hit addr=%h lat=%0d: hit at %0d (i=%0d d=%0d), required at %0d (i=%0d d=%0d)",
                         addr, lat, hit_at, got_i, got_d, lat + 1, !is_d, is_d);
            end
            vectors++;
            if (strobes !== lat) begin
                errors++;
                $display("FAIL xact_strobes addr=%h: %0d strobe cycles, required %0d", addr, strobes, lat);
            end
        end else begin
            exp_err = 1'b1;
            vectors++;
            if (hit_at !== 0 || strobes !== TO) begin
                errors++;
                $display("FAIL timeout addr=%h: hit at %0d strobes %0d, required no hit and %0d strobes",
                         addr, hit_at, strobes, TO);
            end
        end
        vectors++;
        if (imemload !== exp_iload || dmemload !== exp_dload) begin
            errors++;
            $display("FAIL xact_load addr=%h: imemload=%h dmemload=%h, required %h %h",
                     addr, imemload, dmemload, exp_iload, exp_dload);
        end
        vectors++;
        if (ram_err !== exp_err) begin
            errors++;
            $display("FAIL ram_err: got %0d, required %0d", ram_err, exp_err);
        end
    endtask

    // Simultaneous fetch and data request: data first, fetch after, never overlapping.
    task automatic dual(input logic [31:0] ia, input logic [31:0] da, input bit wr,
                        input logic [31:0] wdata, input int lat);
        int d_at = 0, i_at = 0;
        bit overlap = 0;
        @(negedge CLK);
        ram_lat = lat;
        imemaddr = ia; imemREN = 1'b1;
        dmemaddr = da; dmemstore = wdata; dmemWEN = wr; dmemREN = !wr;
        for (int k = 1; k <= 2 * lat + 6 && i_at == 0; k++) begin
            @(negedge CLK);
            if (ihit && dhit) overlap = 1;
            if (dhit && d_at == 0) begin
                d_at = k; dmemREN = 1'b0; dmemWEN = 1'b0;
            end
            if (ihit && i_at == 0) begin
                i_at = k; imemREN = 1'b0;
            end
        end
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        if (wr) ref_mem[da] = wdata; else exp_dload = ref_rd(da);
        exp_iload = ref_rd(ia);
        vectors++;
        if (d_at !== lat + 1 || i_at !== 2 * lat + 3 || overlap) begin
            errors++;
            $display("FAIL dual_order lat=%0d: dhit at %0d ihit at %0d overlap=%0d, required %0d %0d 0",
                     lat, d_at, i_at, overlap, lat + 1, 2 * lat + 3);
        end
        vectors++;
        if (imemload !== exp_iload || dmemload !== exp_dload) begin
            errors++;
            $display("FAIL dual_load: imemload=%h dmemload=%h, required %h %h",
                     imemload, dmemload, exp_iload, exp_dload);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN, flushed, ram_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: ihit dhit ren wen flushed err = %b, required 000000",
                     {ihit, dhit, ramREN, ramWEN, flushed, ram_err});
        end
        vectors++;
        if (imemload !== 32'h0 || dmemload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: %h %h %h %h, required all zero", imemload, dmemload, ramaddr, ramstore);
        end
        nRST = 1'b0;
    endtask

    task automatic test_ifetch;
        ram_mem[32'h0] = 32'h2401000A;
        ref_mem[32'h0] = 32'h2401000A;
        xact(1'b0, 1'b0, 32'h0, 32'h0, 1);
        vectors++;
        if (imemload !== 32'h2401000A) begin
            errors++;
            $display("FAIL ifetch_value: imemload=%h, required 2401000a", imemload);
        end
    endtask

    task automatic test_simultaneous;
        dual(32'h4, 32'h100, 1'b0, 32'h0, 1);
        dual(32'h8, 32'h104, 1'b1, 32'h1234_5678, 2);
        dual(32'h104, 32'h104, 1'b1, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_write;
        xact(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3);
        xact(1'b1, 1'b0, 32'h200, 32'h0, 1);
        vectors++;
        if (dmemload !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_readback: dmemload=%h, required deadbeef", dmemload);
        end
    endtask

    task automatic test_timeout;
        xact(1'b0, 1'b0, 32'h40, 32'h0, TO + 2);
        xact(1'b1, 1'b1, 32'h44, 32'h1111_2222, TO + 3);
        xact(1'b0, 1'b0, 32'h40, 32'h0, TO);
        xact(1'b1, 1'b0, 32'h44, 32'h0, 2);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            logic [31:0] a2 = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            int lat = ($urandom_range(0, 7) == 0) ? TO + 1 + int'($urandom_range(0, 2))
                                                   : int'($urandom_range(1, TO));
            if ($urandom_range(0, 9) < 2)
                dual(a, a2, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, TO)));
            else
                xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, lat);
        end
    endtask

    task automatic test_async_reset;
        @(negedge CLK);
        ram_lat = 3;
        dmemaddr = 32'h300; dmemWEN = 1'b1; dmemstore = 32'h0BAD_0BAD;
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (ramWEN !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: ramWEN=%0d, required 1", ramWEN);
        end
        #2 nRST = 1'b1;
        #1;
        vectors++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ram_err !== 1'b0 || dmemload !== 32'h0) begin
            errors++;
            $display("FAIL areset_drop: ren=%0d wen=%0d err=%0d dmemload=%h, required 0 0 0 0",
                     ramREN, ramWEN, ram_err, dmemload);
        end
        dmemWEN = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        exp_iload = '0; exp_dload = '0; exp_err = 1'b0;
        xact(1'b1, 1'b0, 32'h300, 32'h0, 2);
        xact(1'b0, 1'b0, 32'h0, 32'h0, 1);
    endtask

    task automatic test_halt;
        int d_at = 0, strobes = 0, hits = 0;
        @(negedge CLK);
        ram_lat = 2;
        dmemaddr = 32'h100; dmemREN = 1'b1;
        @(negedge CLK);
        halt = 1'b1;
        for (int k = 2; k <= 8 && d_at == 0; k++) begin
            @(negedge CLK);
            if (dhit) begin d_at = k; dmemREN = 1'b0; end
        end
        dmemREN = 1'b0;
        exp_dload = ref_rd(32'h100);
        vectors++;
        if (d_at !== 3 || dmemload !== exp_dload) begin
            errors++;
            $display("FAIL halt_drain: dhit at %0d dmemload=%h, required 3 %h", d_at, dmemload, exp_dload);
        end
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (flushed !== 1'b1) begin
            errors++;
            $display("FAIL halt_flushed: flushed=%0d, required 1", flushed);
        end
        imemaddr = 32'h8; imemREN = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (ramREN || ramWEN) strobes++;
            if (ihit || dhit) hits++;
        end
        imemREN = 1'b0;
        vectors++;
        if (strobes !== 0 || hits !== 0 || flushed !== 1'b1) begin
            errors++;
            $display("FAIL halt_ignore: strobes=%0d hits=%0d flushed=%0d, required 0 0 1", strobes, hits, flushed);
        end
        halt = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        nRST = 1'b0;
        exp_iload = '0; exp_dload = '0; exp_err = 1'b0;
        vectors++;
        if (flushed !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: flushed=%0d, required 0", flushed);
        end
        xact(1'b0, 1'b0, 32'h8, 32'h0, 1);
    endtask

    initial begin
        nRST = 1'b1;
        imemREN = 1'b0; imemaddr = '0;
        dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
        halt = 1'b0;
        test_reset;
        test_ifetch;
        test_simultaneous;
        test_write;
        test_timeout;
        test_random;
        test_async_reset;
        test_halt;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
